// File: rtl/hamming_secded_decoder.sv
// SECDED decoder for a (16,11) extended Hamming code: two-stage valid/ready
// pipeline with saturating single/double error counters.
module hamming_secded_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      code_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [10:0]      data_out,
  output logic             err_single,
  output logic             err_double,
  output logic [3:0]       syndrome,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_double,
  input  logic             cnt_clr
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Received-word fields
  logic [10:0] d_in;
  logic        p1_in, p2_in, p3_in, p4_in;

  // Stage 1 registers
  logic        s1_valid_q, s1_valid_d;
  logic [10:0] s1_data_q, s1_data_d;
  logic [3:0]  s1_syn_q, s1_syn_d;
  logic        s1_par_q, s1_par_d;

  // Stage 2 registers
  logic        s2_valid_q, s2_valid_d;
  logic [10:0] s2_data_q, s2_data_d;
  logic        s2_single_q, s2_single_d;
  logic        s2_double_q, s2_double_d;
  logic [3:0]  s2_syn_q, s2_syn_d;

  // Counters
  logic [CNT_W-1:0] cnt_single_q, cnt_single_d;
  logic [CNT_W-1:0] cnt_double_q, cnt_double_d;

  logic        en;
  logic        out_xfer;
  logic [10:0] flip_mask;

  assign en       = !s2_valid_q || out_ready;
  assign in_ready = en || rst;
  assign out_xfer = s2_valid_q && out_ready;

  assign d_in  = code_in[15:5];
  assign p1_in = code_in[3];
  assign p2_in = code_in[2];
  assign p3_in = code_in[1];
  assign p4_in = code_in[0];

  // Stage 1: syndrome and overall parity of the received word
  always_comb begin
    s1_valid_d  = in_valid;
    s1_data_d   = d_in;
    s1_syn_d[0] = p1_in ^ d_in[0] ^ d_in[1] ^ d_in[3] ^ d_in[4] ^ d_in[6]
                  ^ d_in[8] ^ d_in[10];
    s1_syn_d[1] = p2_in ^ d_in[0] ^ d_in[2] ^ d_in[3] ^ d_in[5] ^ d_in[6]
                  ^ d_in[9] ^ d_in[10];
    s1_syn_d[2] = p3_in ^ d_in[1] ^ d_in[2] ^ d_in[3] ^ d_in[7] ^ d_in[8]
                  ^ d_in[9] ^ d_in[10];
    s1_syn_d[3] = p4_in ^ d_in[4] ^ d_in[5] ^ d_in[6] ^ d_in[7] ^ d_in[8]
                  ^ d_in[9] ^ d_in[10];
    s1_par_d    = ^code_in;
  end

  // Hamming position -> data bit; check-bit positions (1,2,4,8) and 0 flip nothing
  always_comb begin
    flip_mask = 11'd0;
    case (s1_syn_q)
      4'd3:    flip_mask = 11'b000_0000_0001;
      4'd5:    flip_mask = 11'b000_0000_0010;
      4'd6:    flip_mask = 11'b000_0000_0100;
      4'd7:    flip_mask = 11'b000_0000_1000;
      4'd9:    flip_mask = 11'b000_0001_0000;
      4'd10:   flip_mask = 11'b000_0010_0000;
      4'd11:   flip_mask = 11'b000_0100_0000;
      4'd12:   flip_mask = 11'b000_1000_0000;
      4'd13:   flip_mask = 11'b001_0000_0000;
      4'd14:   flip_mask = 11'b010_0000_0000;
      4'd15:   flip_mask = 11'b100_0000_0000;
      default: flip_mask = 11'd0;
    endcase
  end

  // Stage 2: classify and correct; odd overall parity always means a single error
  always_comb begin
    s2_valid_d  = s1_valid_q;
    s2_syn_d    = s1_syn_q;
    s2_single_d = s1_par_q;
    s2_double_d = !s1_par_q && (s1_syn_q != 4'd0);
    s2_data_d   = s1_par_q ? (s1_data_q ^ flip_mask) : s1_data_q;
  end

  // Clear has priority over an increment in the same cycle
  always_comb begin
    cnt_single_d = cnt_single_q;
    cnt_double_d = cnt_double_q;
    if (cnt_clr) begin
      cnt_single_d = '0;
      cnt_double_d = '0;
    end else if (out_xfer) begin
      if (s2_single_q && (cnt_single_q != CNT_MAX)) begin
        cnt_single_d = cnt_single_q + CNT_ONE;
      end
      if (s2_double_q && (cnt_double_q != CNT_MAX)) begin
        cnt_double_d = cnt_double_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_syn_q     <= '0;
      s1_par_q     <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      s2_single_q  <= 1'b0;
      s2_double_q  <= 1'b0;
      s2_syn_q     <= '0;
      cnt_single_q <= '0;
      cnt_double_q <= '0;
    end else begin
      if (en) begin
        s1_valid_q  <= s1_valid_d;
        s1_data_q   <= s1_data_d;
        s1_syn_q    <= s1_syn_d;
        s1_par_q    <= s1_par_d;
        s2_valid_q  <= s2_valid_d;
        s2_data_q   <= s2_data_d;
        s2_single_q <= s2_single_d;
        s2_double_q <= s2_double_d;
        s2_syn_q    <= s2_syn_d;
      end
      cnt_single_q <= cnt_single_d;
      cnt_double_q <= cnt_double_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign data_out   = s2_data_q;
  assign err_single = s2_single_q;
  assign err_double = s2_double_q;
  assign syndrome   = s2_syn_q;
  assign cnt_single = cnt_single_q;
  assign cnt_double = cnt_double_q;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Bench for hamming_secded_decoder: position-based reference decoder, per-cycle
// compare against a 2-slot pipeline model, plus literal checks of known words.
module tb_hamming_secded_decoder;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [15:0]      code_in = 16'h0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [10:0]      data_out;
  logic             err_single, err_double;
  logic [3:0]       syndrome;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [CNT_W-1:0] cnt_single, cnt_double;
  logic             cnt_clr = 1'b0;

  hamming_secded_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .in_valid(in_valid),
    .in_ready(in_ready), .data_out(data_out), .err_single(err_single),
    .err_double(err_double), .syndrome(syndrome), .out_valid(out_valid),
    .out_ready(out_ready), .cnt_single(cnt_single), .cnt_double(cnt_double),
    .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nout = 0;
  int ncmp = 0;
  int errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hamming position of each code_in bit (0 = overall parity p0)
  function automatic int bit_pos(input int b);
    case (b)
      0: return 8;  1: return 4;  2: return 2;  3: return 1;  4: return 0;
      5: return 3;  6: return 5;  7: return 6;  8: return 7;  9: return 9;
      10: return 10; 11: return 11; 12: return 12; 13: return 13;
      14: return 14; default: return 15;
    endcase
  endfunction

  function automatic void ref_decode(input logic [15:0] c, output logic [10:0] d,
                                     output logic es, output logic ed,
                                     output logic [3:0] s);
    int sy = 0;
    int q = 0;
    for (int b = 0; b < 16; b++) begin
      if (c[b]) begin
        sy = sy ^ bit_pos(b);
        q  = q ^ 1;
      end
    end
    d = c[15:5];
    if (q == 1) begin
      for (int i = 0; i < 11; i++)
        if (bit_pos(i + 5) == sy) d[i] = ~d[i];
    end
    es = (q == 1);
    ed = (q == 0) && (sy != 0);
    s  = 4'(sy);
  endfunction

  function automatic logic [15:0] encode(input logic [10:0] data);
    logic [15:0] c;
    int sy = 0;
    c = {data, 5'b0};
    for (int b = 5; b < 16; b++)
      if (c[b]) sy = sy ^ bit_pos(b);
    c[3] = sy[0];
    c[2] = sy[1];
    c[1] = sy[2];
    c[0] = sy[3];
    c[4] = ^c;
    return c;
  endfunction

  // Model pipeline: slot A is the newest accepted entry, slot B drives the outputs
  logic        ma_v = 1'b0, mb_v = 1'b0;
  logic [15:0] ma_c = 16'h0, mb_c = 16'h0;
  int          m_cs = 0, m_cd = 0;
  bit          mok = 1'b0;

  always @(negedge clk) begin
    logic [10:0] ed;
    logic        es, edd;
    logic [3:0]  esy;
    ref_decode(mb_c, ed, es, edd, esy);
    if (mok) begin
      chk("out_valid", 32'(out_valid), 32'(mb_v));
      chk("in_ready", 32'(in_ready), 32'(rst || !mb_v || out_ready));
      chk("cnt_single", 32'(cnt_single), 32'(m_cs));
      chk("cnt_double", 32'(cnt_double), 32'(m_cd));
      if (mb_v) begin
        chk("data_out", 32'(data_out), 32'(ed));
        chk("err_single", 32'(err_single), 32'(es));
        chk("err_double", 32'(err_double), 32'(edd));
        chk("syndrome", 32'(syndrome), 32'(esy));
        chk("flags_exclusive", 32'(err_single && err_double), 32'(0));
      end
    end
    if (rst) begin
      ma_v = 1'b0; mb_v = 1'b0; ma_c = 16'h0; mb_c = 16'h0;
      m_cs = 0; m_cd = 0; mok = 1'b1;
    end else begin
      if (mb_v && out_ready) begin
        nout++;
        if (!cnt_clr && es  && m_cs < (1 << CNT_W) - 1) m_cs++;
        if (!cnt_clr && edd && m_cd < (1 << CNT_W) - 1) m_cd++;
      end
      if (cnt_clr) begin m_cs = 0; m_cd = 0; end
      if (!mb_v || out_ready) begin
        if (in_valid) nvec++;
        mb_v = ma_v; mb_c = ma_c;
        ma_v = in_valid; ma_c = code_in;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] c);
    bit ok = 1'b0;
    in_valid = 1'b1;
    code_in  = c;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    if (!ok) chk("send_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic send_check(input logic [15:0] c, input logic [10:0] xd,
                            input logic xs, input logic xdd, input logic [3:0] xsy,
                            input int xcs, input int xcd);
    send(c);
    tick();
    chk("lit_out_valid", 32'(out_valid), 32'(1));
    chk("lit_data_out", 32'(data_out), 32'(xd));
    chk("lit_err_single", 32'(err_single), 32'(xs));
    chk("lit_err_double", 32'(err_double), 32'(xdd));
    chk("lit_syndrome", 32'(syndrome), 32'(xsy));
    tick();
    chk("lit_cnt_single", 32'(cnt_single), 32'(xcs));
    chk("lit_cnt_double", 32'(cnt_double), 32'(xcd));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] md;
    logic        ms, mdd;
    logic [3:0]  msy;
    logic [15:0] c;
    logic [10:0] held;
    int          n0;

    // Reference model pinned against hand-derived words
    chk("model_encode_1", 32'(encode(11'h001)), 32'h003C);
    ref_decode(16'h001C, md, ms, mdd, msy);
    chk("model_1C", {16'(md), 4'(ms), 4'(mdd), 8'(msy)}, {16'h0001, 4'h1, 4'h0, 8'h03});
    ref_decode(16'h005C, md, ms, mdd, msy);
    chk("model_5C", {16'(md), 4'(ms), 4'(mdd), 8'(msy)}, {16'h0002, 4'h0, 4'h1, 8'h06});

    repeat (3) tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_data_out", 32'(data_out), 32'(0));
    chk("rst_flags", 32'({err_single, err_double}), 32'(0));
    chk("rst_syndrome", 32'(syndrome), 32'(0));
    chk("rst_counters", 32'({cnt_single, cnt_double}), 32'(0));

    send_check(16'h003C, 11'h001, 1'b0, 1'b0, 4'd0, 0, 0);
    send_check(16'h001C, 11'h001, 1'b1, 1'b0, 4'd3, 1, 0);
    send_check(16'h005C, 11'h002, 1'b0, 1'b1, 4'd6, 1, 1);
    send_check(16'h002C, 11'h001, 1'b1, 1'b0, 4'd0, 2, 1);
    send_check(16'h0034, 11'h001, 1'b1, 1'b0, 4'd1, 3, 1);

    // Back-to-back stream with 0, 1 or 2 flipped bits
    for (int i = 0; i < 40; i++) begin
      int k, b1, b2;
      c  = encode(11'($urandom));
      k  = int'($urandom_range(0, 2));
      b1 = int'($urandom_range(0, 15));
      b2 = (b1 + int'($urandom_range(1, 15))) % 16;
      if (k >= 1) c[b1] = ~c[b1];
      if (k == 2) c[b2] = ~c[b2];
      send(c);
    end
    repeat (4) tick();

    // Backpressure: 3-cycle stall mid-stream
    n0 = nout;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          c = encode(11'(i * 37 + 5));
          if (i == 2) c[7] = ~c[7];
          send(c);
        end
      end
      begin
        tick();
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'(0));
        chk("stall_out_valid", 32'(out_valid), 32'(1));
        held = data_out;
        repeat (2) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 32'(0));
          chk("stall_hold", 32'(data_out), 32'(held));
        end
        tick();
        out_ready = 1'b1;
      end
    join
    repeat (4) tick();
    chk("stall_delivered", 32'(nout - n0), 32'(5));

    // Saturation at 2^CNT_W-1
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      c = encode(11'(i + 100));
      c[5 + i] = ~c[5 + i];
      send(c);
    end
    repeat (4) tick();
    chk("sat_cnt_single", 32'(cnt_single), 32'(3));

    // Clear coinciding with an error transfer
    c = encode(11'h155);
    c[9] = ~c[9];
    send(c);
    tick();
    chk("pre_clr_valid", 32'(out_valid && err_single), 32'(1));
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_wins", 32'(cnt_single), 32'(0));

    // Reset with two words in flight plus one offered during reset
    c = encode(11'h0F0);
    c[12] = ~c[12];
    send(c);
    repeat (3) tick();
    chk("pre_rst_cnt", 32'(cnt_single), 32'(1));
    send(c);
    send(c);
    rst = 1'b1;
    in_valid = 1'b1;
    code_in = c;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_counters", 32'({cnt_single, cnt_double}), 32'(0));
    tick();
    chk("midrst_drop", 32'(out_valid), 32'(0));

    send_check(16'h003C, 11'h001, 1'b0, 1'b0, 4'd0, 0, 0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule

// File: doc/hamming_secded_decoder.md
HAMMING_SECDED_DECODER -- requirements
Module: hamming_secded_decoder

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, which sets the width of each error counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port code_in, input, 16 bits: received codeword {d[10:0], p0, p1, p2, p3, p4}, so d[i] = code_in[5+i], p0 = [4], p1 = [3], p2 = [2], p3 = [1], p4 = [0].
REQ-005 The block SHALL have port in_valid, input, 1 bit, and port in_ready, output, 1 bit: input handshake; a word transfers when both are high.
REQ-006 The block SHALL have port data_out, output, 11 bits: decoded data, corrected where correctable.
REQ-007 The block SHALL have port err_single, output, 1 bit: single-bit error detected and corrected.
REQ-008 The block SHALL have port err_double, output, 1 bit: uncorrectable double-bit error detected.
REQ-009 The block SHALL have port syndrome, output, 4 bits: syndrome {s4, s3, s2, s1} of the output word.
REQ-010 The block SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: output handshake; a word transfers when both are high.
REQ-011 The block SHALL have port cnt_single, output, CNT_W bits, and port cnt_double, output, CNT_W bits: saturating error counters.
REQ-012 The block SHALL have port cnt_clr, input, 1 bit: synchronous clear of both counters.

Function
REQ-013 The block SHALL compute the syndrome bits from the received word as follows:
- s1 = p1^d0^d1^d3^d4^d6^d8^d10
- s2 = p2^d0^d2^d3^d5^d6^d9^d10
- s3 = p3^d1^d2^d3^d7^d8^d9^d10
- s4 = p4^d4^d5^d6^d7^d8^d9^d10
REQ-014 The block SHALL compute the overall parity q as the XOR of all 16 received bits, where even parity is expected.
REQ-015 The block SHALL classify each word as follows:
- s=0 and q=0: no error.
- s=0 and q=1: p0 error; err_single=1, data unchanged.
- s≠0 and q=1: single error at Hamming position s; err_single=1.
- s≠0 and q=0: err_double=1, data_out = raw d[10:0], no correction.
REQ-016 The block SHALL map Hamming positions 3,5,6,7,9,10,11,12,13,14,15 to d0..d10 respectively for correction, inverting exactly that data bit.
REQ-017 For s = 1, 2, 4 or 8 (check-bit error), the block SHALL leave data unchanged.
REQ-018 err_single and err_double SHALL never both be 1.
REQ-019 The pipeline SHALL have 2 register stages:
- S1 registers code_in, s and q.
- S2 registers data_out, the flags and syndrome.
- Latency is 2 clk edges from input transfer to out_valid with no stall.
REQ-020 The block SHALL use a global advance signal en = !out_valid || out_ready, with in_ready = en.
- When en=1: S1 loads {in_valid, code_in}, and S2 loads S1 contents.
- When en=0: both stages hold.
REQ-021 While out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-022 Throughput SHALL be one word per cycle when out_ready is held at 1.
REQ-023 Each counter SHALL increment by 1 only on an output transfer (out_valid && out_ready) carrying its flag.
REQ-024 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 If cnt_clr and an increment occur in the same cycle, cnt_clr SHALL win and the counter SHALL become 0.
REQ-026 Data_out, flags and syndrome SHALL be don't-care when out_valid=0, except after reset, where they are 0.

Reset
REQ-027 With rst=1 at a clk edge, the block SHALL clear all state: S1/S2 valid=0, out_valid=0, data_out=0, err_single=0, err_double=0, syndrome=0, cnt_single=0, cnt_double=0.
REQ-028 While rst=1, in_ready SHALL be 1, and the block SHALL discard words offered or in flight.
REQ-029 Reset mid-stream SHALL drop in-flight words with no counter update.
REQ-030 The first word accepted after rst falls SHALL appear after 2 cycles.

Verification
REQ-031 Clean word: code_in=0x003C -> out_valid 2 cycles later, data_out=0x001, err_single=0, err_double=0, syndrome=0.
REQ-032 Data-bit error: code_in=0x001C (d0 flipped) -> data_out=0x001, err_single=1, syndrome=3, cnt_single=1.
REQ-033 Double error: code_in=0x005C (d0, d1 flipped) -> data_out=0x002, err_double=1, syndrome=6, cnt_double=1.
REQ-034 Parity-bit errors: code_in=0x002C (p0 flipped) -> data_out=0x001, err_single=1, syndrome=0; code_in=0x0034 (p1 flipped) -> data_out=0x001, err_single=1, syndrome=1.
REQ-035 Backpressure: stream 5 words with out_ready=0 for 3 cycles mid-stream -> in_ready=0 during stall, outputs held, all 5 words delivered in order, none dropped or duplicated.
REQ-036 Counter saturation, clear and reset:
- With CNT_W=2, 5 single-error words -> cnt_single=3.
- cnt_clr asserted in the same cycle as an error transfer -> 0.
- rst asserted with 2 words in flight -> out_valid=0 next cycle and counters 0.
